ifu_fetch_queue: RTL and testbench

- Instruction-fetch front end: consumer of the program-counter stream, the reader side of the PC/instruction-memory interface.
- Owns the fetch PC and issues word reads to a synchronous instruction ROM with fixed 1-cycle latency.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- Flushes the buffer and discards in-flight reads on branch/jump redirects.

---
 rtl/cpu_defs.sv | 21 ++
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/ifu_fetch_queue.sv | 113 +++++++++++
 tb/tb_ifu_fetch_queue.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
// Module   : cpu_defs (package)
// Brief    : Shared CPU front-end constants and the fetch-buffer entry type.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_defs;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam int          WORD_BYTES = 4;
    localparam int          INSTR_W    = 32;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    // One buffered fetch: the returned instruction plus the PC it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Brief    : DEPTH-entry synchronous FIFO of {instr, pc} with flush.
//            Head data reads as zero while the FIFO is empty.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import cpu_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head,
    output logic [PTR_W:0]     count
);

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [PTR_W:0]     r_count;
    logic               w_pop;

    // A pop only takes effect when there is something to pop.
    assign w_pop = pop & (r_count != '0);

    // Storage array: written on push, never reset (contents gated on output).
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    // Pointers and count; flush wins over push/pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (push && !w_pop) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end else if (!push && w_pop) begin
                r_count <= r_count - (PTR_W+1)'(1);
            end
        end
    end

    assign head  = (r_count != '0) ? r_mem[r_rptr] : '0;
    assign count = r_count;

`ifndef SYNTHESIS
    // Overflow checker: a push into a full FIFO without a pop loses data.
    always @(posedge clk) begin
        if (rst_n && !flush && push && !w_pop) begin
            assert (r_count != (PTR_W+1)'(DEPTH));
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/ifu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_queue
// Brief    : Instruction fetch front end. Owns the fetch PC, issues word
//            reads to a 1-cycle-latency ROM under a credit limit, buffers
//            returned instructions and flushes on redirect.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch_queue #(
    parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               out_valid,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_pc,
    input  logic               out_ready,
    output logic [PTR_W:0]     occupancy
);

    import cpu_defs::*;

    localparam logic [0:0] c_st_run   = 1'b0;
    localparam logic [0:0] c_st_flush = 1'b1;

    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_req_pc;
    logic               r_inflight;
    logic [0:0]         r_state;

    logic [PTR_W:0]     w_count;
    logic [PTR_W+1:0]   w_credit_sum;
    logic               w_req;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_redirect_target;
    fetch_entry_t       w_head;
    fetch_entry_t       w_push_data;

    // Credit: buffered entries plus the outstanding read must leave room.
    assign w_credit_sum      = {1'b0, w_count} + {{(PTR_W+1){1'b0}}, r_inflight};
    assign w_req             = reset & ~redirect_valid
                             & (w_credit_sum < (PTR_W+2)'(DEPTH));
    assign w_push            = r_inflight & ~redirect_valid & (r_state == c_st_run);
    assign w_pop             = (w_count != '0) & out_ready;
    assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign w_push_data       = '{instr: imem_rdata, pc: r_req_pc};

    // Fetch PC: redirect target, else advance one word per issued request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redirect_target;
        end else if (w_req) begin
            r_fetch_pc <= r_fetch_pc + 32'(WORD_BYTES);
        end
    end

    // In-flight tracker: remembers the PC of the read whose data arrives next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inflight <= 1'b0;
            r_req_pc   <= '0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_req_pc <= r_fetch_pc;
            end
        end
    end

    // RUN/FLUSH: one flush cycle after every redirect drops late responses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_run;
        end else if (redirect_valid) begin
            r_state <= c_st_flush;
        end else begin
            r_state <= c_st_run;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .head      (w_head),
        .count     (w_count)
    );

    assign imem_req  = w_req;
    assign imem_addr = r_fetch_pc;
    assign out_valid = (w_count != '0);
    assign out_instr = w_head.instr;
    assign out_pc    = w_head.pc;
    assign occupancy = w_count;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch_queue
// Brief    : Self-checking bench: queue-based reference model compared every
//            cycle, plus directed literal checks of key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic [2:0]  occupancy;

    logic [31:0] rom_xor = 32'h0;

    int tests = 0;
    int fails = 0;

    ifu_fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data = address ^ rom_xor one cycle after a request,
    // garbage otherwise so any stray write is visible.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (imem_addr ^ rom_xor) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [63:0] m_q[$];
    logic [31:0] m_pc       = 32'h0000_3000;
    logic [31:0] m_req_pc   = 32'h0;
    logic [31:0] m_req_data = 32'h0;
    bit          m_inf      = 1'b0;

    always @(negedge clk) begin
        logic        e_req, e_valid;
        logic [31:0] e_pc, e_instr, e_occ;
        if (!reset) begin
            chk("m_req",   imem_req,  1'b0);
            chk("m_valid", out_valid, 1'b0);
            chk("m_occ",   occupancy, 32'd0);
            chk("m_pc",    out_pc,    32'd0);
            chk("m_instr", out_instr, 32'd0);
            chk("m_addr",  imem_addr, 32'h0000_3000);
            m_q.delete();
            m_pc  = 32'h0000_3000;
            m_inf = 1'b0;
        end else begin
            e_occ   = m_q.size();
            e_valid = (m_q.size() != 0);
            e_pc    = e_valid ? m_q[0][31:0]  : 32'h0;
            e_instr = e_valid ? m_q[0][63:32] : 32'h0;
            e_req   = !redirect_valid && ((m_q.size() + int'(m_inf)) < 4);
            chk("m_req",   imem_req,  e_req);
            chk("m_addr",  imem_addr, m_pc);
            chk("m_valid", out_valid, e_valid);
            chk("m_occ",   occupancy, e_occ);
            chk("m_pc",    out_pc,    e_pc);
            chk("m_instr", out_instr, e_instr);
            if (redirect_valid) begin
                m_q.delete();
                m_inf = 1'b0;
                m_pc  = redirect_pc & ~32'd3;
            end else begin
                if (e_valid && out_ready) void'(m_q.pop_front());
                if (m_inf) m_q.push_back({m_req_data, m_req_pc});
                if (e_req) begin
                    m_req_pc   = m_pc;
                    m_req_data = m_pc ^ rom_xor;
                    m_pc       = m_pc + 32'd4;
                end
                m_inf = e_req;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        tick; tick;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_occ",   occupancy, 32'd0);
        chk("rst_req",   imem_req,  1'b0);
        chk("rst_addr",  imem_addr, 32'h0000_3000);

        // Reset release, streaming with addr-as-data
        reset = 1'b1; #1;
        chk("a_req0",  imem_req,  1'b1);
        chk("a_addr0", imem_addr, 32'h0000_3000);
        tick; #1 chk("a_addr1", imem_addr, 32'h0000_3004);
        tick; #1 chk("a_addr2", imem_addr, 32'h0000_3008);
        chk("a_valid2", out_valid, 1'b1);
        chk("a_pc2",    out_pc,    32'h0000_3000);
        chk("a_instr2", out_instr, 32'h0000_3000);
        repeat (3) tick;

        // Stall until full, then async reset with a full FIFO
        out_ready = 1'b0;
        repeat (10) tick;
        chk("full_occ", occupancy, 32'd4);
        reset = 1'b0; #1;
        chk("ar_valid", out_valid, 1'b0);
        chk("ar_occ",   occupancy, 32'd0);
        rom_xor = 32'h1234_0000;
        tick;
        reset = 1'b1; #1;
        chk("b_req0",  imem_req,  1'b1);
        chk("b_addr0", imem_addr, 32'h0000_3000);

        // Saturation with out_ready low for 10 cycles
        repeat (10) tick; #1;
        chk("b_occ",   occupancy, 32'd4);
        chk("b_req",   imem_req,  1'b0);
        chk("b_pc",    out_pc,    32'h0000_3000);
        chk("b_instr", out_instr, 32'h1234_3000);
        out_ready = 1'b1;
        repeat (6) tick;

        // Redirect coincident with a pop
        redirect_valid = 1'b1; redirect_pc = 32'h0000_7000; #1;
        chk("e_popping", out_valid, 1'b1);
        tick;
        redirect_valid = 1'b0; #1;
        chk("e_valid", out_valid, 1'b0);
        chk("e_occ",   occupancy, 32'd0);
        chk("e_addr",  imem_addr, 32'h0000_7000);
        repeat (4) tick;

        // Redirect with 2 buffered and one read in flight; target has low bits set
        out_ready = 1'b0;
        tick;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_4001; #1;
        chk("c_occ", occupancy, 32'd2);
        chk("c_req", imem_req,  1'b0);
        tick;
        redirect_valid = 1'b0; out_ready = 1'b1; #1;
        chk("c_valid1", out_valid, 1'b0);
        chk("c_addr1",  imem_addr, 32'h0000_4000);
        tick; tick; #1;
        chk("c_valid3", out_valid, 1'b1);
        chk("c_pc3",    out_pc,    32'h0000_4000);
        repeat (3) tick;

        // Back-to-back redirects: last one wins
        redirect_valid = 1'b1; redirect_pc = 32'h0000_5000;
        tick;
        redirect_pc = 32'h0000_6000;
        tick;
        redirect_valid = 1'b0; #1;
        chk("d_addr", imem_addr, 32'h0000_6000);
        tick; tick; #1;
        chk("d_pc", out_pc, 32'h0000_6000);
        repeat (3) tick;

        // PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick;
        redirect_valid = 1'b0; #1;
        chk("f_addr0", imem_addr, 32'hFFFF_FFF8);
        tick; #1 chk("f_addr1", imem_addr, 32'hFFFF_FFFC);
        tick; #1 chk("f_addr2", imem_addr, 32'h0000_0000);
        chk("f_pc", out_pc, 32'hFFFF_FFF8);
        repeat (4) tick;

        out_ready = 1'b0;
        repeat (2) tick;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
